// File: rtl/fp_switch_sequencer.sv
// Front-panel switch sequencer: one prioritised command pulse per press, then a debounce lockout.
// Build option FP_AUTOREPEAT_EN lets held REPEAT_MASK switches re-trigger without a release.
module fp_switch_sequencer #(
  parameter int              N_SW         = 7,
  parameter int              DBNCE_BITS   = 16,
  parameter int              PULSE_CYCLES = 3,
  parameter logic [N_SW-1:0] RUN_MASK     = N_SW'(7'b0000001),
  parameter logic [N_SW-1:0] REPEAT_MASK  = N_SW'(7'b0000110)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halted,
  input  logic            at_boundary,
  input  logic            step_mode,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_pulse,
  output logic            trig,
  output logic            sw_active,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_LOCKOUT, S_RELEASE} state_t;

  // One counter serves both the pulse width (up to 15) and the lockout window.
  localparam int             CW         = (DBNCE_BITS > 4) ? DBNCE_BITS : 4;
  localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  LOCK_LAST  = CW'({DBNCE_BITS{1'b1}});

  state_t          r_state;
  state_t          w_next;
  logic [N_SW-1:0] r_sync1;
  logic [N_SW-1:0] r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [N_SW-1:0] r_pulse;
  logic            r_trig;
  logic [N_SW-1:0] w_elig;
  logic [N_SW-1:0] w_lowest;
  logic            w_rel_ok;
  logic            w_pulse_done;
  logic            w_lock_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_elig = '0;
    if (halted)
      w_elig = r_sync2;
    else if (at_boundary && step_mode)
      w_elig = r_sync2 & RUN_MASK;
  end

  // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority switch.
  assign w_lowest     = w_elig & (~w_elig + N_SW'(1));
  assign w_pulse_done = (r_cnt == PULSE_LAST);
  assign w_lock_done  = (r_cnt == LOCK_LAST);

`ifdef FP_AUTOREPEAT_EN
  assign w_rel_ok = ((r_sync2 & ~REPEAT_MASK) == '0);
`else
  assign w_rel_ok = (r_sync2 == '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_elig != '0) w_next = S_PULSE;
      S_PULSE:   if (w_pulse_done) w_next = S_LOCKOUT;
      S_LOCKOUT: if (w_lock_done)  w_next = S_RELEASE;
      S_RELEASE: if (w_rel_ok)     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_pulse <= '0;
      r_trig  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_elig != '0) begin
            r_pulse <= w_lowest;
            r_trig  <= 1'b1;
          end
        end
        S_PULSE: begin
          if (w_pulse_done) begin
            r_cnt   <= '0;
            r_pulse <= '0;
            r_trig  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_LOCKOUT: begin
          if (w_lock_done)
            r_cnt <= '0;
          else
            r_cnt <= r_cnt + CW'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    sw_pulse  = r_pulse;
    trig      = r_trig;
    sw_active = (r_state == S_LOCKOUT);
    busy      = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_fp_switch_sequencer.sv
// Bench for fp_switch_sequencer: vector table, corner sequences, and randomized run against a timing model.
// Define FP_AUTOREPEAT_EN for both RTL and bench to exercise the auto-repeat build.
module tb_fp_switch_sequencer;
  localparam int         PC   = 3;
  localparam int         LW   = 16;
  localparam logic [6:0] RUN  = 7'b0000001;
  localparam logic [6:0] REP  = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       halted = 1'b0;
  logic       atb = 1'b0;
  logic       step = 1'b0;
  logic [6:0] sw = '0;
  logic [6:0] sw_pulse;
  logic       trig, sw_active, busy;

  fp_switch_sequencer #(
    .N_SW(7), .DBNCE_BITS(4), .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset(rst), .halted(halted), .at_boundary(atb), .step_mode(step),
    .sw(sw), .sw_pulse(sw_pulse), .trig(trig), .sw_active(sw_active), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  string phase = "reset";

  // Reference model: time-stamped capture, outputs derived from age since capture.
  logic [6:0] m_s1 = '0, m_s2 = '0, m_pulse = '0;
  bit         m_idle = 1'b1;
  int         m_t = 0, m_cap = 0;
  logic [6:0] e_pulse;
  logic       e_trig, e_act, e_busy;

  function automatic logic [6:0] lowbit(input logic [6:0] v);
    logic [6:0] r = '0;
    for (int i = 6; i >= 0; i--) if (v[i]) r = 7'd1 << i;
    return r;
  endfunction

  function automatic bit relok(input logic [6:0] v);
`ifdef FP_AUTOREPEAT_EN
    return (v & ~REP) == 7'd0;
`else
    return v == 7'd0;
`endif
  endfunction

  task automatic model_edge();
    logic [6:0] elig;
    int age;
    if (!rst) begin
      m_idle = 1'b1; m_s1 = '0; m_s2 = '0; m_pulse = '0;
    end else begin
      m_t++;
      if (m_idle) begin
        elig = halted ? m_s2 : (atb && step) ? (m_s2 & RUN) : 7'd0;
        if (elig != 7'd0) begin
          m_idle = 1'b0; m_cap = m_t; m_pulse = lowbit(elig);
        end
      end else if (m_t - m_cap >= PC + LW + 1 && relok(m_s2)) begin
        m_idle = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
    age     = m_t - m_cap;
    e_busy  = !m_idle;
    e_pulse = (!m_idle && age < PC) ? m_pulse : 7'd0;
    e_trig  = (e_pulse != 7'd0);
    e_act   = !m_idle && age >= PC && age < PC + LW;
  endtask

  int   cyc_idx, n_starts, first_idx, last_idx, spacing_bad, pulse_cnt, act_cnt, busy_cnt;
  logic [6:0] first_val;
  logic prev_trig;

  task automatic clr_stats();
    cyc_idx = 0; n_starts = 0; first_idx = -1; last_idx = 0; spacing_bad = 0;
    pulse_cnt = 0; act_cnt = 0; busy_cnt = 0; first_val = '0; prev_trig = 1'b0;
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    total++;
    if (sw_pulse !== e_pulse || trig !== e_trig || sw_active !== e_act || busy !== e_busy) begin
      bad++;
      $display("FAIL %s cyc %0d: got pulse=%b trig=%b act=%b busy=%b, want pulse=%b trig=%b act=%b busy=%b",
               phase, cyc_idx, sw_pulse, trig, sw_active, busy, e_pulse, e_trig, e_act, e_busy);
    end
    if (trig && !prev_trig) begin
      n_starts++;
      if (n_starts == 1) begin
        first_idx = cyc_idx; first_val = sw_pulse;
      end else if (cyc_idx - last_idx != PC + LW + 2) begin
        spacing_bad++;
      end
      last_idx = cyc_idx;
    end
    prev_trig = trig;
    if (trig)      pulse_cnt++;
    if (sw_active) act_cnt++;
    if (busy)      busy_cnt++;
    cyc_idx++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       h, a, s;
    logic [6:0] sw;
    int         hold;
    logic [6:0] first;
    int         starts;
  } vec_t;

  vec_t vt[7];

  initial begin
`ifdef FP_AUTOREPEAT_EN
    int rep_starts = 5;
`else
    int rep_starts = 1;
`endif
    vt[0] = '{1'b1, 1'b0, 1'b0, 7'b0001000,  40, 7'b0001000, 1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 7'b0101000,  40, 7'b0001000, 1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 7'b0000011,  40, 7'b0000001, 1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 7'b0000011,  40, 7'b0000000, 0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 7'b0000001,  40, 7'b0000000, 0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 7'b0000010, 100, 7'b0000010, rep_starts};
    vt[6] = '{1'b1, 1'b0, 1'b0, 7'b0001000, 100, 7'b0001000, 1};

    clr_stats();
    repeat (3) cyc();
    expect_int("reset_state", int'({sw_pulse, trig, sw_active, busy}), 0);

    foreach (vt[k]) begin
      phase = $sformatf("vec%0d", k);
      do_reset();
      halted = vt[k].h; atb = vt[k].a; step = vt[k].s;
      clr_stats();
      sw = vt[k].sw;
      repeat (vt[k].hold) cyc();
      sw = '0;
      repeat (45) cyc();
      expect_int({phase, "_starts"}, n_starts, vt[k].starts);
      expect_int({phase, "_pulse_cycles"}, pulse_cnt, PC * vt[k].starts);
      expect_int({phase, "_active_cycles"}, act_cnt, LW * vt[k].starts);
      expect_int({phase, "_spacing"}, spacing_bad, 0);
      if (vt[k].starts > 0) begin
        expect_int({phase, "_first_val"}, int'(first_val), int'(vt[k].first));
        expect_int({phase, "_latency"}, first_idx, 2);
      end else begin
        expect_int({phase, "_busy"}, busy_cnt, 0);
      end
    end

    // Release mid-lockout, second press inside lockout released before RELEASE.
    phase = "lockout_press";
    do_reset();
    halted = 1'b1; atb = 1'b0; step = 1'b0;
    clr_stats();
    sw = 7'b0010000;
    repeat (10) cyc();
    sw = '0;
    repeat (2) cyc();
    sw = 7'b0100000;
    repeat (6) cyc();
    sw = '0;
    repeat (30) cyc();
    expect_int("lockout_starts", n_starts, 1);
    expect_int("lockout_first_val", int'(first_val), int'(7'b0010000));
    expect_int("lockout_busy_cycles", busy_cnt, PC + LW + 1);
    expect_int("lockout_active_cycles", act_cnt, LW);

    // Reset during the second pulse cycle.
    phase = "reset_mid";
    do_reset();
    clr_stats();
    sw = 7'b0000100;
    repeat (4) cyc();
    expect_int("reset_mid_pre_pulse", pulse_cnt, 2);
    rst = 1'b0;
    cyc();
    expect_int("reset_mid_outputs", int'({sw_pulse, trig, sw_active, busy}), 0);
    sw = '0;
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    clr_stats();
    sw = 7'b0000100;
    repeat (30) cyc();
    sw = '0;
    repeat (10) cyc();
    expect_int("reset_mid_repress_starts", n_starts, 1);
    expect_int("reset_mid_repress_latency", first_idx, 2);
    expect_int("reset_mid_repress_val", int'(first_val), int'(7'b0000100));

    // Randomized run, every cycle compared against the model.
    phase = "random";
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)
        sw = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      if ($urandom_range(0, 19) == 0) begin
        halted = ($urandom_range(0, 3) != 0);
        atb    = 1'($urandom_range(0, 1));
        step   = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_switch_sequencer.md
# fp_switch_sequencer

Parametrised front-panel momentary-switch sequencer; successor to the fixed seven-switch trigger/lockout block. It synchronises N_SW switch inputs and gates them by CPU run status. It issues one one-hot command pulse of programmable width, then holds a power-of-two lockout window for debounce. It re-arms only after release, or auto-repeats held switches when compiled in. It sits between the panel switch pins and the CPU major-state sequencer.

## Interface
- N_SW, 7: number of momentary switches; bit 0 has highest priority.
- DBNCE_BITS, 16: lockout window length is 2**DBNCE_BITS cycles.
- PULSE_CYCLES, 3: width of the command pulse in cycles (1..15).
- RUN_MASK, 7'b0000001: switches honoured while not halted (e.g. CONT); width N_SW.
- REPEAT_MASK, 7'b0000110: switches allowed to auto-repeat (used only with FP_AUTOREPEAT_EN); width N_SW.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- halted  in  1  CPU in a halt/wait major state; synchronous to clk.
- at_boundary  in  1  CPU in F0/D0/E0; synchronous to clk.
- step_mode  in  1  single-step or halt switch on; synchronous to clk.
- sw  in  N_SW  raw asynchronous switch levels, 1 = pressed.
- sw_pulse  out  N_SW  one-hot command pulse, registered.
- trig  out  1  OR of sw_pulse, registered.
- sw_active  out  1  high throughout LOCKOUT.
- busy  out  1  state != IDLE.

## Operation
- sw passes through a 2-flop synchroniser giving sw_s. The raw sw is never used elsewhere.
- eligible = halted ? sw_s : (at_boundary & step_mode) ? (sw_s & RUN_MASK) : 0.
- States: IDLE, PULSE, LOCKOUT, RELEASE. The encoding is implementation choice.
- IDLE:
  - If eligible != 0, load sw_pulse with the lowest set bit of eligible, clear cnt, and go to PULSE.
  - Otherwise stay in IDLE.
- PULSE:
  - Hold sw_pulse; cnt increments each cycle.
  - When cnt == PULSE_CYCLES-1, clear sw_pulse and cnt and go to LOCKOUT.
- LOCKOUT:
  - sw_active = 1; cnt increments.
  - When cnt == 2**DBNCE_BITS-1, go to RELEASE.
  - cnt is DBNCE_BITS wide and wraps to 0 on exit.
- RELEASE: go to IDLE when the release condition (see Configuration) holds; otherwise wait.
- Simultaneous presses: only the lowest-index eligible bit pulses. Other switches are ignored until the next arming.
- Switch changes during PULSE/LOCKOUT have no effect. Only IDLE and RELEASE sample sw_s.
- Qualifier changes during PULSE do not cut the pulse short.
- Reset mid-operation:
  - Next edge forces IDLE, cnt = 0, sw_pulse = 0, trig = 0.
  - Synchroniser flops clear to 0.
- Reset values: sw_pulse = 0, trig = 0, sw_active = 0, busy = 0.

## Timing
- Let E0 be the first rising edge sampling sw = 1.
  - sw_s is high after E1.
  - Capture occurs at E2, provided the qualifiers are valid at E2.
  - sw_pulse and trig are high from after E2 through PULSE_CYCLES cycles.
- Latency from pin to pulse: 2 cycles plus the edge-alignment uncertainty.
- sw_active:
  - Rises on the edge sw_pulse falls.
  - Stays high for exactly 2**DBNCE_BITS cycles.
- RELEASE lasts at least 1 cycle; IDLE is re-entered on the edge after the release condition is seen.
- Minimum spacing between pulse starts: PULSE_CYCLES + 2**DBNCE_BITS + 2 cycles.
- busy is high from the capture edge until re-entry to IDLE.

## Configuration
- Macro: FP_AUTOREPEAT_EN.
- Without it:
  - The release condition is sw_s == 0.
  - Every command requires a full release of all switches.
- With it:
  - The release condition is (sw_s & ~REPEAT_MASK) == 0.
  - A held REPEAT_MASK switch re-triggers once per PULSE_CYCLES + 2**DBNCE_BITS + 2 cycles while still eligible.
  - Non-repeat switches still require release.

## Test plan
Bench parameters: N_SW = 7, DBNCE_BITS = 4, PULSE_CYCLES = 3, defaults otherwise.
- Halted, sw = 7'b0001000 held 40 cycles, released -> sw_pulse = 7'b0001000 for 3 cycles starting 2 cycles after the first sampling edge; sw_active high 16 cycles; exactly one pulse (macro off).
- Halted, sw = 7'b0101000 in the same cycle -> sw_pulse = 7'b0001000 only; trig 3 cycles.
- Not halted, at_boundary = 1, step_mode = 1, sw = 7'b0000011 -> sw_pulse = 7'b0000001. Repeat with step_mode = 0 -> no pulse, busy stays 0.
- Pulse/lockout timing:
  - Halted; press sw[4] and release mid-LOCKOUT.
  - Press sw[5] during LOCKOUT and release before RELEASE -> no second pulse.
  - busy returns to 0 at cycle 3 + 16 + 1 after capture.
- Reset mid-operation: drive reset = 0 during PULSE cycle 2 -> next edge sw_pulse = 0, sw_active = 0, busy = 0. Pressing again after reset = 1 pulses normally.
- FP_AUTOREPEAT_EN, halted, sw[1] held 100 cycles -> pulses start every 21 cycles (5 pulses). Same with sw[3] -> single pulse.
